elevator: RTL and testbench
===========================

// Module: elevator
// PURPOSE
// - Cabin model driven by target_controller: moves one floor at a time on
//   up/down commands and operates the door on request.
// - Reports the current floor and the door state. target_controller uses door
//   rising and falling edges, so door must change cleanly and without glitches.
// - Fully synchronous, except for the asynchronous reset.
// PARAMETERS
// - NUM_FLOORS   8   floors 0..NUM_FLOORS-1; must be <= 8 because floor is 3 bits.
// - FLOOR_TICKS  20  clock cycles of travel per floor, at least 1.
// - DOOR_TICKS   5   clock cycles for a full door open or close, at least 1.
// PORTS
// - clk        in   1  rising-edge clock for all state.
// - rst        in   1  asynchronous, active-high reset.
// - door_open  in   1  1 = request door open; 0 = request door closed.
// - updown     in   2  2'b01 = up; 2'b10 = down; 2'b00 and 2'b11 = stop.
// - door       out  1  1 = door fully open; registered.
// - floor      out  3  current floor; registered.
// BEHAVIOUR
// - Reset (async, active-high):
//   - floor = 0, door = 0, state = IDLE, travel and door counters = 0.
// - States and transitions:
//   - IDLE: door closed, cabin stationary.
//   - UP / DOWN: cabin travelling.
//   - OPENING: door opening.
//   - OPEN: door fully open.
//   - CLOSING: door closing.
// - IDLE:
//   - door_open = 1 -> OPENING. This has priority over updown.
//   - Else updown = 01 and floor < NUM_FLOORS-1 -> UP.
//   - Else updown = 10 and floor > 0 -> DOWN.
//   - Up at the top floor, down at floor 0, and 00/11 are ignored; state stays IDLE.
// - UP / DOWN:
//   - The travel counter increments each cycle.
//   - On reaching FLOOR_TICKS, floor steps by +/-1 and the counter clears.
//   - The state stays UP/DOWN while the same command remains valid.
//   - Command drops to 00/11 -> IDLE. Any partial travel is discarded; floor is unchanged.
//   - Command reverses -> the counter restarts in the new direction.
//   - Limits: a floor never leaves 0..NUM_FLOORS-1. Reaching the end floor -> IDLE.
//   - door_open = 1 while moving -> finish the current cycle, go to IDLE, then
//     OPENING on the next cycle. Floor does not advance on that cycle.
// - OPENING:
//   - After DOOR_TICKS cycles -> OPEN, with door = 1 on the same edge.
//   - door_open = 0 before then -> CLOSING, which takes the same elapsed ticks to close.
// - OPEN:
//   - door stays 1 while door_open = 1. updown is ignored.
//   - door_open = 0 -> CLOSING.
// - CLOSING:
//   - door = 0 on entry.
//   - After DOOR_TICKS cycles -> IDLE.
//   - door_open = 1 during CLOSING -> OPENING.
// - Motion is inhibited in every door state: no floor change while door = 1 or
//   the door is in transit.
// - Outputs change only on the rising edge of clk, or asynchronously on reset.
//   Each door transition is a single clean 0->1 or 1->0 edge.
// - Reset asserted mid-move or mid-door: immediate return to the reset values above.
// - Counters are wide enough for max(FLOOR_TICKS, DOOR_TICKS); no wrap-around.
// TESTING
// Bench parameters: FLOOR_TICKS = 4, DOOR_TICKS = 2.
// - Reset -> floor = 0, door = 0. Hold updown = 10 for 20 cycles -> floor stays 0.
// - updown = 01 for 12 cycles from IDLE at 0 -> floor goes 1, 2, 3, one step
//   every 4 cycles; then updown = 00 -> floor holds at 3.
// - At floor 3, door_open = 1 -> door = 1 after 2 cycles. updown = 01 while
//   open -> floor stays 3. door_open = 0 -> door = 0 on the next edge; IDLE
//   after 2 cycles.
// - Start at 6, updown = 01 for 40 cycles -> floor reaches 7 and stays at 7.
//   Then updown = 10 -> 6 after 4 cycles.
// - updown = 01 for 3 cycles, then 00 -> floor unchanged (partial travel
//   discarded). Reversal mid-travel restarts the 4-cycle count.
// - Assert rst while moving or while the door is open -> floor = 0 and door = 0
//   immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/elevator.sv
// Cabin model for a single elevator shaft.
//
// The cabin moves one floor at a time on up/down commands and operates the
// door on request. Floor and door are registered outputs, so the door only
// ever makes single, clean 0->1 or 1->0 transitions on a clock edge.
//
// Ports:
//   clk        rising-edge clock for all state
//   rst        asynchronous, active-high reset
//   door_open  1 = request door open, 0 = request door closed
//   updown     2'b01 = up, 2'b10 = down, 2'b00 / 2'b11 = stop
//   door       1 = door fully open (registered)
//   floor      current floor, 0..NUM_FLOORS-1 (registered)

module elevator #(
    parameter int unsigned NUM_FLOORS  = 8,
    parameter int unsigned FLOOR_TICKS = 20,
    parameter int unsigned DOOR_TICKS  = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       door_open,
    input  logic [1:0] updown,
    output logic       door,
    output logic [2:0] floor
);

    localparam int unsigned MAX_TICKS = (FLOOR_TICKS > DOOR_TICKS) ? FLOOR_TICKS : DOOR_TICKS;
    localparam int unsigned CW        = $clog2(MAX_TICKS + 1);

    localparam logic [2:0]    TOP_FLOOR = 3'(NUM_FLOORS - 1);
    localparam logic [CW-1:0] FT        = CW'(FLOOR_TICKS);
    localparam logic [CW-1:0] DT        = CW'(DOOR_TICKS);
    localparam logic [CW-1:0] ONE       = CW'(1);

    typedef enum logic [2:0] {
        StIdle,
        StUp,
        StDown,
        StOpening,
        StOpen,
        StClosing
    } state_t;

    state_t        state_q, state_d;
    logic [2:0]    floor_q, floor_d;
    logic [CW-1:0] tcnt_q, tcnt_d;
    // Door position: 0 = closed, DOOR_TICKS = fully open. Closing counts it
    // back down, so an aborted opening takes as long to close as it ran.
    logic [CW-1:0] dcnt_q, dcnt_d;
    logic          door_q, door_d;

    logic          up_cmd, dn_cmd;
    logic          move_up, move_dn;
    logic [CW-1:0] t_base, t_tick;
    logic          door_step_open, door_step_close;
    logic [CW-1:0] d_tick;

    assign up_cmd = (updown == 2'b01);
    assign dn_cmd = (updown == 2'b10);

    always_comb begin
        state_d         = state_q;
        floor_d         = floor_q;
        tcnt_d          = tcnt_q;
        dcnt_d          = dcnt_q;
        move_up         = 1'b0;
        move_dn         = 1'b0;
        t_base          = '0;
        t_tick          = '0;
        door_step_open  = 1'b0;
        door_step_close = 1'b0;
        d_tick          = '0;

        unique case (state_q)
            StIdle: begin
                if (door_open) begin
                    door_step_open = 1'b1;
                end else if (up_cmd && floor_q != TOP_FLOOR) begin
                    move_up = 1'b1;
                end else if (dn_cmd && floor_q != 3'd0) begin
                    move_dn = 1'b1;
                end
            end
            StUp: begin
                if (door_open) begin
                    // Stop first; the door request is served from IDLE.
                    state_d = StIdle;
                    tcnt_d  = '0;
                end else if (up_cmd) begin
                    move_up = 1'b1;
                    t_base  = tcnt_q;
                end else if (dn_cmd && floor_q != 3'd0) begin
                    move_dn = 1'b1;
                end else begin
                    state_d = StIdle;
                    tcnt_d  = '0;
                end
            end
            StDown: begin
                if (door_open) begin
                    state_d = StIdle;
                    tcnt_d  = '0;
                end else if (dn_cmd) begin
                    move_dn = 1'b1;
                    t_base  = tcnt_q;
                end else if (up_cmd && floor_q != TOP_FLOOR) begin
                    move_up = 1'b1;
                end else begin
                    state_d = StIdle;
                    tcnt_d  = '0;
                end
            end
            StOpening: begin
                if (door_open) begin
                    door_step_open = 1'b1;
                end else begin
                    door_step_close = 1'b1;
                end
            end
            StOpen: begin
                if (!door_open) begin
                    door_step_close = 1'b1;
                end
            end
            StClosing: begin
                if (door_open) begin
                    door_step_open = 1'b1;
                end else begin
                    door_step_close = 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Travel tick: the edge that starts or reverses a move counts as the
        // first tick of travel in the new direction.
        if (move_up || move_dn) begin
            t_tick = t_base + ONE;
            if (t_tick == FT) begin
                tcnt_d  = '0;
                floor_d = move_up ? floor_q + 3'd1 : floor_q - 3'd1;
                if ((move_up && floor_d == TOP_FLOOR) || (move_dn && floor_d == 3'd0)) begin
                    state_d = StIdle;
                end else begin
                    state_d = move_up ? StUp : StDown;
                end
            end else begin
                tcnt_d  = t_tick;
                state_d = move_up ? StUp : StDown;
            end
        end

        if (door_step_open) begin
            d_tick  = dcnt_q + ONE;
            dcnt_d  = d_tick;
            state_d = (d_tick == DT) ? StOpen : StOpening;
        end else if (door_step_close) begin
            d_tick  = dcnt_q - ONE;
            dcnt_d  = d_tick;
            state_d = (d_tick == '0) ? StIdle : StClosing;
        end

        door_d = (state_d == StOpen);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            floor_q <= 3'd0;
            tcnt_q  <= '0;
            dcnt_q  <= '0;
            door_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            floor_q <= floor_d;
            tcnt_q  <= tcnt_d;
            dcnt_q  <= dcnt_d;
            door_q  <= door_d;
        end
    end

    assign door  = door_q;
    assign floor = floor_q;

endmodule

// File: tb/tb_elevator.sv
// Directed testbench for elevator with FLOOR_TICKS = 4, DOOR_TICKS = 2.
// Inputs are driven 1 time unit after a rising edge; outputs are sampled there.

module tb_elevator;

    logic       clk;
    logic       rst;
    logic       door_open;
    logic [1:0] updown;
    logic       door;
    logic [2:0] floor;

    int n_checks = 0;
    int n_fail   = 0;

    elevator #(
        .NUM_FLOORS (8),
        .FLOOR_TICKS(4),
        .DOOR_TICKS (2)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .door_open(door_open),
        .updown   (updown),
        .door     (door),
        .floor    (floor)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        door_open = 1'b0;
        updown    = 2'b00;
        step(2);
        n_checks++;
        if (floor !== 3'd0) begin
            n_fail++; $display("FAIL reset_floor: got %0d want 0", floor);
        end
        n_checks++;
        if (door !== 1'b0) begin
            n_fail++; $display("FAIL reset_door: got %0b want 0", door);
        end
        rst    = 1'b0;
        updown = 2'b10;
        for (int i = 0; i < 20; i++) begin
            step(1);
            n_checks++;
            if (floor !== 3'd0) begin
                n_fail++; $display("FAIL down_at_bottom[%0d]: got %0d want 0", i, floor);
            end
        end
        updown = 2'b00;
        step(1);
    endtask

    task automatic test_up_travel();
        logic [2:0] exp;
        updown = 2'b01;
        for (int i = 1; i <= 12; i++) begin
            step(1);
            exp = 3'(i / 4);
            n_checks++;
            if (floor !== exp) begin
                n_fail++; $display("FAIL up_travel[%0d]: got %0d want %0d", i, floor, exp);
            end
        end
        updown = 2'b00;
        step(4);
        n_checks++;
        if (floor !== 3'd3) begin
            n_fail++; $display("FAIL stop_hold: got %0d want 3", floor);
        end
    endtask

    task automatic test_door();
        door_open = 1'b1;
        step(1);
        n_checks++;
        if (door !== 1'b0) begin
            n_fail++; $display("FAIL door_opening_1: got %0b want 0", door);
        end
        step(1);
        n_checks++;
        if (door !== 1'b1) begin
            n_fail++; $display("FAIL door_open_2: got %0b want 1", door);
        end
        updown = 2'b01;
        step(6);
        n_checks++;
        if (floor !== 3'd3 || door !== 1'b1) begin
            n_fail++; $display("FAIL up_while_open: got floor %0d door %0b want 3 1", floor, door);
        end
        door_open = 1'b0;
        updown    = 2'b00;
        step(1);
        n_checks++;
        if (door !== 1'b0) begin
            n_fail++; $display("FAIL door_close_edge: got %0b want 0", door);
        end
        // IDLE again after the second closing edge: a move started now lands in 4.
        step(1);
        updown = 2'b01;
        step(3);
        n_checks++;
        if (floor !== 3'd3) begin
            n_fail++; $display("FAIL after_close_3: got %0d want 3", floor);
        end
        step(1);
        n_checks++;
        if (floor !== 3'd4) begin
            n_fail++; $display("FAIL after_close_4: got %0d want 4", floor);
        end
        updown = 2'b00;
        step(1);
    endtask

    task automatic test_top();
        logic [2:0] exp;
        updown = 2'b01;
        step(8);
        updown = 2'b00;
        step(1);
        n_checks++;
        if (floor !== 3'd6) begin
            n_fail++; $display("FAIL reach_6: got %0d want 6", floor);
        end
        updown = 2'b01;
        for (int i = 1; i <= 40; i++) begin
            step(1);
            exp = (i >= 4) ? 3'd7 : 3'd6;
            n_checks++;
            if (floor !== exp) begin
                n_fail++; $display("FAIL top_limit[%0d]: got %0d want %0d", i, floor, exp);
            end
        end
        updown = 2'b10;
        step(3);
        n_checks++;
        if (floor !== 3'd7) begin
            n_fail++; $display("FAIL down_from_top_3: got %0d want 7", floor);
        end
        step(1);
        n_checks++;
        if (floor !== 3'd6) begin
            n_fail++; $display("FAIL down_from_top_4: got %0d want 6", floor);
        end
        updown = 2'b00;
        step(1);
    endtask

    task automatic test_partial_reverse();
        updown = 2'b10;
        step(3);
        updown = 2'b00;
        step(2);
        n_checks++;
        if (floor !== 3'd6) begin
            n_fail++; $display("FAIL partial_hold: got %0d want 6", floor);
        end
        updown = 2'b10;
        step(3);
        n_checks++;
        if (floor !== 3'd6) begin
            n_fail++; $display("FAIL partial_discard_3: got %0d want 6", floor);
        end
        step(1);
        n_checks++;
        if (floor !== 3'd5) begin
            n_fail++; $display("FAIL partial_discard_4: got %0d want 5", floor);
        end
        step(2);
        updown = 2'b01;
        step(3);
        n_checks++;
        if (floor !== 3'd5) begin
            n_fail++; $display("FAIL reverse_3: got %0d want 5", floor);
        end
        step(1);
        n_checks++;
        if (floor !== 3'd6) begin
            n_fail++; $display("FAIL reverse_4: got %0d want 6", floor);
        end
        updown = 2'b00;
        step(1);
    endtask

    task automatic test_move_door();
        updown = 2'b10;
        step(2);
        door_open = 1'b1;
        step(1);
        n_checks++;
        if (floor !== 3'd6 || door !== 1'b0) begin
            n_fail++; $display("FAIL move_door_stop: got floor %0d door %0b want 6 0", floor, door);
        end
        step(1);
        n_checks++;
        if (door !== 1'b0) begin
            n_fail++; $display("FAIL move_door_opening: got %0b want 0", door);
        end
        step(1);
        n_checks++;
        if (door !== 1'b1) begin
            n_fail++; $display("FAIL move_door_open: got %0b want 1", door);
        end
        step(4);
        n_checks++;
        if (floor !== 3'd6 || door !== 1'b1) begin
            n_fail++; $display("FAIL move_door_hold: got floor %0d door %0b want 6 1", floor, door);
        end
    endtask

    task automatic test_async_reset();
        // Door is open at floor 6 here.
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if (floor !== 3'd0 || door !== 1'b0) begin
            n_fail++; $display("FAIL async_rst_open: got floor %0d door %0b want 0 0", floor, door);
        end
        step(1);
        rst       = 1'b0;
        door_open = 1'b0;
        updown    = 2'b01;
        step(6);
        n_checks++;
        if (floor !== 3'd1) begin
            n_fail++; $display("FAIL moving_before_rst: got %0d want 1", floor);
        end
        #1;
        rst = 1'b1;
        #1;
        n_checks++;
        if (floor !== 3'd0) begin
            n_fail++; $display("FAIL async_rst_moving: got %0d want 0", floor);
        end
        step(1);
        rst    = 1'b0;
        updown = 2'b00;
        step(1);
    endtask

    task automatic test_open_abort();
        door_open = 1'b1;
        step(1);
        door_open = 1'b0;
        step(1);
        n_checks++;
        if (door !== 1'b0) begin
            n_fail++; $display("FAIL abort_door: got %0b want 0", door);
        end
        // One tick opened, one tick closed: already IDLE, so a move lands after 4.
        updown = 2'b01;
        step(3);
        n_checks++;
        if (floor !== 3'd0) begin
            n_fail++; $display("FAIL abort_move_3: got %0d want 0", floor);
        end
        step(1);
        n_checks++;
        if (floor !== 3'd1) begin
            n_fail++; $display("FAIL abort_move_4: got %0d want 1", floor);
        end
        updown = 2'b00;
        step(1);
    endtask

    initial begin
        test_reset();
        test_up_travel();
        test_door();
        test_top();
        test_partial_reverse();
        test_move_door();
        test_async_reset();
        test_open_abort();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
